// File: rtl/axi4lite_native_initiator.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_native_initiator
// Brief    : Native valid/ready memory port to single-outstanding AXI4-lite
//            initiator with a sticky transaction watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_native_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  output logic        busy,
  output logic        timeout
);

  localparam logic [31:0] C_TMO = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d;
  logic        aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic        timeout_q, timeout_d;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, ready_q, busy_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    instr_d   = instr_q;
    rdata_d   = rdata_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          if (mem_wstrb == 4'b0000) begin
            state_d = RD_ADDR;
          end else begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = WR_REQ;
          end
        end
      end
      RD_ADDR: if (arvalid_q && mem_axi_arready) state_d = RD_DATA;
      RD_DATA: begin
        if (mem_axi_rvalid) begin
          rdata_d = mem_axi_rdata;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave only once both are accepted.
        if (awvalid_q && mem_axi_awready) aw_pend_d = 1'b0;
        if (wvalid_q && mem_axi_wready)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d)      state_d   = WR_RESP;
      end
      WR_RESP: if (mem_axi_bvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cnt_d     = (state_q == IDLE) ? 32'd0 :
                (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    timeout_d = timeout_q | ((C_TMO != 32'd0) && (cnt_d == C_TMO));
  end

  // Handshake outputs are registered from next-state so no input reaches a port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      instr_q   <= 1'b0;
      rdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      arvalid_q <= (state_d == RD_ADDR);
      rready_q  <= (state_d == RD_DATA);
      awvalid_q <= (state_d == WR_REQ) && aw_pend_d;
      wvalid_q  <= (state_d == WR_REQ) && w_pend_d;
      bready_q  <= (state_d == WR_RESP);
      ready_q   <= (state_d == DONE);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign mem_ready       = ready_q;
  assign mem_rdata       = rdata_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = wstrb_q;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = {instr_q, 2'b00};
  assign mem_axi_rready  = rready_q;
  assign busy            = busy_q;
  assign timeout         = timeout_q;

endmodule
`default_nettype wire

// File: doc/axi4lite_native_initiator.md
# axi4lite_native_initiator

AXI4-lite initiator that converts the CPU-side native memory interface (valid/ready, word address, byte strobes) into single-outstanding AXI4-lite read and write transactions. It sits between a native-interface core and any AXI4-lite responder, including the `axi4_memory` bench model. AW and W channels are issued together and may complete in either order. A watchdog flags responders that stall a transaction.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles a transaction may stay outstanding before `timeout` sets; 0 disables the watchdog.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_valid` in 1: native request valid; held until `mem_ready`.
- `mem_instr` in 1: request is an instruction fetch.
- `mem_addr` in 32: byte address; passed to AXI unchanged.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte strobes; 4'b0000 means read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data; valid while `mem_ready`=1.
- `mem_axi_awvalid` out 1, `mem_axi_awready` in 1, `mem_axi_awaddr` out 32, `mem_axi_awprot` out 3.
- `mem_axi_wvalid` out 1, `mem_axi_wready` in 1, `mem_axi_wdata` out 32, `mem_axi_wstrb` out 4.
- `mem_axi_bvalid` in 1, `mem_axi_bready` out 1.
- `mem_axi_arvalid` out 1, `mem_axi_arready` in 1, `mem_axi_araddr` out 32, `mem_axi_arprot` out 3.
- `mem_axi_rvalid` in 1, `mem_axi_rready` out 1, `mem_axi_rdata` in 32.
- `busy` out 1: state is not IDLE.
- `timeout` out 1: sticky watchdog flag.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE
  - When `mem_valid`=1, latch addr, wdata, wstrb and instr.
  - If wstrb==0, go to RD_ADDR; else set `aw_pend`=`w_pend`=1 and go to WR_REQ.
- RD_ADDR
  - `arvalid`=1, `araddr`=latched addr, `arprot`={instr,2'b00}.
  - On `arvalid`&&`arready`, go to RD_DATA.
- RD_DATA
  - `rready`=1.
  - On `rvalid`, latch `mem_rdata` and go to DONE.
- WR_REQ
  - `awvalid`=`aw_pend`, `wvalid`=`w_pend`, `awprot`=3'b000.
  - Each pending flag clears on its own handshake; the two may clear in the same cycle or in either order.
  - When both flags are clear, go to WR_RESP.
- WR_RESP
  - `bready`=1.
  - On `bvalid`, go to DONE.
- DONE
  - `mem_ready`=1 for exactly one cycle, then IDLE.
  - `mem_rdata` holds its last read value otherwise; it is not updated by writes.
- An asserted valid never drops before its handshake, and AXI address/data/strobe outputs stay stable while valid is high.
- One transaction outstanding at most; `mem_valid` is ignored outside IDLE.
- Latched request fields are used for the whole transaction; native inputs may change after IDLE without effect.
- Watchdog
  - 32-bit counter clears in IDLE and increments every non-IDLE cycle.
  - When the counter equals `TIMEOUT_CYCLES` (nonzero), `timeout` sets.
  - It stays set until `reset`; the transaction keeps waiting (AXI rules forbid abandoning it).
  - The counter saturates and never wraps.

## Timing
- Reset values: all AXI valid/ready outputs 0; `mem_ready` 0; `mem_rdata` 0; AXI address/data/strobe/prot outputs 0; `busy` 0; `timeout` 0; state IDLE; pending flags 0.
- Reset asserted mid-transaction drops all valids immediately (asynchronous). No completion is reported for the aborted transaction.
- All outputs are registered; no combinational path from any input to any output.
- Minimum read latency:
  - `mem_valid` sampled at edge 0.
  - `arvalid` high in cycle 1; `arready` in cycle 1 → `rready` in cycle 2.
  - `rvalid` in cycle 2 → `mem_ready` in cycle 3 (3 cycles total).
- Minimum write latency: AW and W both accepted at edge 1 → `bready` cycle 2, `bvalid` cycle 2 → `mem_ready` cycle 3.
- Each cycle of responder ready/valid delay adds exactly one cycle.
- `mem_ready` and the next IDLE sampling never coincide, so a held `mem_valid` is never double-issued.

## Test plan
- Read, zero-wait responder, addr 0x0000_0104 with memory word 0xDEAD_BEEF → `arvalid` cycle 1, `mem_ready` cycle 3, `mem_rdata`=0xDEAD_BEEF, `arprot`=3'b000.
- Instruction fetch at 0x0 → `arprot`=3'b100. Responder holds `arready` low 5 cycles → `araddr` stable throughout, `mem_ready` at cycle 8.
- Write 0x1122_3344, strobe 4'b0101 to 0x10:
  - W accepted 2 cycles before AW → `wvalid` drops after its handshake, `awvalid` held; exactly one `bready` phase; `mem_ready` once.
  - Memory word becomes 0xXX22_XX44.
- Write to 0x2000_0000 with data 123456789 against `axi4_memory` run with `axi_test` randomisation → bench `tests_passed`=1; no valid drops before handshake across 10,000 random-delay transactions.
- `TIMEOUT_CYCLES`=16, responder never asserts `rvalid` → `timeout` rises after 16 non-IDLE cycles; `rready` stays 1; `mem_ready` stays 0.
- `reset` asserted while in WR_RESP → all outputs at reset values within the same cycle. After release, a new read completes normally and `timeout` reads 0.
